// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : input_debouncer
// Description : Conditions raw board keys and switches. Each bit is optionally
//               inverted to active-high, passed through a two-flop
//               synchroniser, then debounced by a per-bit stability counter.
//               Produces clean levels plus registered one-cycle edge strobes.
// Ports       : clk        - system clock
//               reset      - synchronous, active-high reset
//               raw_in     - asynchronous raw pins, {keys, switches}
//               stable_out - debounced, polarity-corrected levels
//               rise_pulse - one-cycle strobe per bit on stable 0->1
//               fall_pulse - one-cycle strobe per bit on stable 1->0
//               any_change - one-cycle strobe, OR of all bit strobes
// Revision    : 1.0 - initial release
// ============================================================================
module input_debouncer #(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter logic [WIDTH-1:0] INVERT_MASK     = WIDTH'(8'hF0),
    parameter int               CNT_W           = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    // Terminal count: a bit flips on the cycle its counter already holds
    // this value while still disagreeing, so the counter never wraps.
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] w_in_pol;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] w_flip;

    // Inversion happens before the synchroniser so everything downstream
    // works in active-high terms.
    assign w_in_pol = raw_in ^ INVERT_MASK;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_in_pol;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic [CNT_W-1:0] r_cnt;
            logic             w_diff;

            assign w_diff    = (r_sync2[i] != stable_out[i]);
            assign w_flip[i] = w_diff && (r_cnt == c_cnt_max);

            // Any single agreeing cycle restarts the count, so bounces
            // shorter than the debounce window never propagate.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (!w_diff || (r_cnt == c_cnt_max)) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

    // Strobes are registered alongside stable_out so they coincide with the
    // first cycle the new level is visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_out <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
            any_change <= 1'b0;
        end else begin
            stable_out <= stable_out ^ w_flip;
            rise_pulse <= w_flip & r_sync2;
            fall_pulse <= w_flip & ~r_sync2;
            any_change <= |w_flip;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_debouncer
// Description : Directed testbench for input_debouncer with DEBOUNCE_CYCLES=4,
//               WIDTH=8, INVERT_MASK=8'hF0. Expected values are hand-derived.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

    logic       clk;
    logic       reset;
    logic [7:0] raw_in;
    logic [7:0] stable_out;
    logic [7:0] rise_pulse;
    logic [7:0] fall_pulse;
    logic       any_change;

    int n_tests;
    int n_fail;

    input_debouncer #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (4),
        .INVERT_MASK     (8'hF0),
        .CNT_W           (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .stable_out (stable_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .any_change (any_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] st,
                             input logic [7:0] ri, input logic [7:0] fa, input logic an);
        check8({tag, ".stable"}, stable_out, st);
        check8({tag, ".rise"},   rise_pulse, ri);
        check8({tag, ".fall"},   fall_pulse, fa);
        check8({tag, ".any"},    {7'b0, any_change}, {7'b0, an});
    endtask

    // Call right after the raw change (or reset release) is driven: the next
    // edge is the capture edge, the update lands on the 6th edge.
    task automatic expect_change(input string tag, input logic [7:0] old_v,
                                 input logic [7:0] new_v, input logic [7:0] ri,
                                 input logic [7:0] fa);
        for (int k = 1; k <= 5; k++) begin
            step();
            check_out({tag, ".wait"}, old_v, 8'h00, 8'h00, 1'b0);
        end
        step();
        check_out({tag, ".edge"}, new_v, ri, fa, 1'b1);
        step();
        check_out({tag, ".after"}, new_v, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        raw_in  = 8'hF0;

        // 1. Reset behaviour
        step();
        step();
        step();
        check_out("reset", 8'h00, 8'h00, 8'h00, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            check_out("idle", 8'h00, 8'h00, 8'h00, 1'b0);
        end

        // 2. Clean press of key0 (active-low bit 4)
        raw_in = 8'hE0;
        expect_change("press", 8'h00, 8'h10, 8'h10, 8'h00);

        // 3. Bounce on switch bit 0: 3-cycle pulses must be rejected
        raw_in = 8'hE1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_out("bounce1", 8'h10, 8'h00, 8'h00, 1'b0);
        end
        raw_in = 8'hE0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_out("bounce0", 8'h10, 8'h00, 8'h00, 1'b0);
        end
        raw_in = 8'hE1;
        expect_change("settle", 8'h10, 8'h11, 8'h01, 8'h00);

        // Return switch 0 low to reach stable 8'h10
        raw_in = 8'hE0;
        expect_change("sw0off", 8'h11, 8'h10, 8'h00, 8'h01);

        // 4. Release key0 and raise switches 1:0 in the same cycle
        raw_in = 8'hF3;
        expect_change("multi", 8'h10, 8'h03, 8'h03, 8'h10);

        // 5. Reset mid-count: target polarity-corrected value 8'h8C
        raw_in = 8'h7C;
        for (int k = 0; k < 4; k++) begin
            step();
            check_out("midcnt", 8'h03, 8'h00, 8'h00, 1'b0);
        end
        reset = 1'b1;
        step();
        check_out("midrst", 8'h00, 8'h00, 8'h00, 1'b0);
        step();
        check_out("midrst2", 8'h00, 8'h00, 8'h00, 1'b0);
        reset = 1'b0;
        expect_change("postrst", 8'h00, 8'h8C, 8'h8C, 8'h00);

        // 6. Long hold after a change: exactly one strobe, level constant
        raw_in = 8'hF0;
        expect_change("hold", 8'h8C, 8'h00, 8'h00, 8'h8C);
        for (int k = 0; k < 1000; k++) begin
            step();
            check_out("longhold", 8'h00, 8'h00, 8'h00, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
